// File: rtl/mb_scheduler_pkg.sv
// Shared types and geometry helpers for the intra-prediction block path.
// Used by the scheduler, the extractor and the predictor.
package intra_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      PRESENT,
      DONE
   } state_t;

   localparam int MBNUM_W = 13;

   function automatic int ncol(input int width);
      return width / 4;
   endfunction

   function automatic int nrow(input int length);
      return length / 4;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/mb_scheduler_if.sv
// Block bus between the scheduler and the extractor/predictor pair.
// The scheduler is the master; the predictor returns blk_ready.
interface mb_scheduler_if;
   import intra_pkg::*;

   logic               ext_enable;
   logic [MBNUM_W-1:0] mbnumber;
   logic               blk_valid;
   logic               blk_ready;
   logic               top_avail;
   logic               left_avail;

   modport master (
      output ext_enable,
      output mbnumber,
      output blk_valid,
      output top_avail,
      output left_avail,
      input  blk_ready
   );

   modport slave (
      input  ext_enable,
      input  mbnumber,
      input  blk_valid,
      input  top_avail,
      input  left_avail,
      output blk_ready
   );

endinterface

// File: rtl/mb_scheduler_addr_counter.sv
// Raster row/col counter over the 4x4 block grid.
// Produces the block index, neighbour flags and the last-block flag.
module mb_addr_counter
   import intra_pkg::*;
#(
   parameter int LENGTH = 256,
   parameter int WIDTH  = 256
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               advance,
   output logic [MBNUM_W-1:0] mbnumber,
   output logic               top_avail,
   output logic               left_avail,
   output logic               last
);

   localparam int NCOL = ncol(WIDTH);
   localparam int NROW = nrow(LENGTH);
   localparam int CW   = cnt_w(NCOL);
   localparam int RW   = cnt_w(NROW);

   localparam logic [CW-1:0] COL_MAX = CW'(NCOL - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(NROW - 1);

   logic [CW-1:0] col, col_n;
   logic [RW-1:0] row, row_n;

   always_comb begin
      row_n = row;
      col_n = col;
      if (clear) begin
         row_n = '0;
         col_n = '0;
      end else if (advance) begin
         if (col == COL_MAX) begin
            col_n = '0;
            row_n = row + RW'(1);
         end else begin
            col_n = col + CW'(1);
         end
      end
   end

   // Flags are registered from the next position so they track row/col.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row        <= '0;
         col        <= '0;
         top_avail  <= 1'b0;
         left_avail <= 1'b0;
      end else begin
         row        <= row_n;
         col        <= col_n;
         top_avail  <= (row_n != '0);
         left_avail <= (col_n != '0);
      end
   end

   assign last = (row == ROW_MAX) && (col == COL_MAX);

   if (is_pow2(NCOL)) begin : g_shift
      assign mbnumber = (MBNUM_W'(row) << $clog2(NCOL)) | MBNUM_W'(col);
   end else begin : g_mul
      assign mbnumber = MBNUM_W'(row) * MBNUM_W'(NCOL) + MBNUM_W'(col);
   end

endmodule

// File: rtl/mb_scheduler.sv
// Frame sequencer: fetch pulse, latency wait, then valid/ready hand-off
// of each 4x4 block to the predictor in raster order.
module mb_scheduler
   import intra_pkg::*;
#(
   parameter int LENGTH    = 256,
   parameter int WIDTH     = 256,
   parameter int FETCH_LAT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   mb_scheduler_if.master bus,
   output logic          busy,
   output logic          frame_done
);

   localparam int LW = $clog2(FETCH_LAT + 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(FETCH_LAT - 1);

   state_t        state, state_n;
   logic [LW-1:0] lat_cnt;
   logic          clear;
   logic          advance;
   logic          last;

   mb_addr_counter #(
      .LENGTH (LENGTH),
      .WIDTH  (WIDTH)
   ) u_addr (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .advance    (advance),
      .mbnumber   (bus.mbnumber),
      .top_avail  (bus.top_avail),
      .left_avail (bus.left_avail),
      .last       (last)
   );

   always_comb begin
      state_n = state;
      clear   = 1'b0;
      advance = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               state_n = FETCH;
               clear   = 1'b1;
            end
         end
         FETCH: state_n = WAIT;
         WAIT: begin
            if (lat_cnt == LAT_LAST) state_n = PRESENT;
         end
         PRESENT: begin
            if (bus.blk_ready) begin
               if (last) begin
                  state_n = DONE;
               end else begin
                  state_n = FETCH;
                  advance = 1'b1;
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            clear   = 1'b1;
         end
         default: state_n = IDLE;
      endcase
      // Abort overrides everything, including a same-cycle handshake.
      if (abort && state != IDLE) begin
         state_n = IDLE;
         clear   = 1'b1;
         advance = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         bus.ext_enable <= 1'b0;
         bus.blk_valid  <= 1'b0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
      end else begin
         state          <= state_n;
         bus.ext_enable <= (state_n == FETCH);
         bus.blk_valid  <= (state_n == PRESENT);
         busy           <= (state_n != IDLE);
         frame_done     <= (state_n == DONE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lat_cnt <= '0;
      end else if (state == WAIT) begin
         lat_cnt <= lat_cnt + LW'(1);
      end else begin
         lat_cnt <= '0;
      end
   end

endmodule

// File: doc/mb_scheduler.md
# mb_scheduler

Sequencing controller for the intra-prediction block extractor. Walks 4x4 block indices across a LENGTH x WIDTH frame in raster order. Per block, pulses the extractor's `enable` with a stable `mbnumber`, waits the extractor's fetch latency, then presents the block to the predictor over a valid/ready handshake. Sits between the frame-level control and the extractor/predictor pair, and also supplies the top/left neighbour-availability flags the predictor needs.

## Interface
Parameters:
- LENGTH, 256, frame height in pixels; multiple of 4
- WIDTH, 256, frame width in pixels; multiple of 4
- FETCH_LAT, 2, cycles from the `ext_enable` edge to valid extractor outputs; ≥1

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  terminate the current frame; no `frame_done`
- ext_enable  out  1  enable to extractor, one cycle per block
- mbnumber  out  13  block index = blk_row*(WIDTH/4)+blk_col
- blk_valid  out  1  extractor outputs valid for the predictor
- blk_ready  in  1  predictor accepts the block
- top_avail  out  1  blk_row != 0
- left_avail  out  1  blk_col != 0
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after the last block is accepted

## Operation
- NCOL = WIDTH/4, NROW = LENGTH/4, NBLK = NCOL*NROW (4096 at defaults; must be ≤ 8192).
- FSM states:
  - IDLE: on `start`, go to FETCH with row = col = 0.
  - FETCH: `ext_enable` = 1 for exactly one cycle, then go to WAIT.
  - WAIT: count FETCH_LAT cycles, then go to PRESENT.
  - PRESENT: hold `blk_valid` = 1 until `blk_valid && blk_ready`. On that handshake, go to DONE if this is the last block; otherwise advance and go to FETCH.
  - DONE: `frame_done` = 1 for one cycle, then go to IDLE.
- Advance rule: col+1. When col = NCOL-1, col wraps to 0 and row+1.
- `mbnumber` is computed from registered row/col, so it is stable from FETCH through PRESENT. It changes only on the cycle after a handshake.
- `top_avail` and `left_avail` are registered alongside row/col and are valid whenever `busy` = 1.
- `start` while busy: ignored.
- `abort` in any non-IDLE state:
  - next state is IDLE;
  - row/col cleared;
  - no `frame_done` pulse;
  - `blk_valid` drops on the next cycle.
- `abort` with a simultaneous handshake: abort wins and no advance occurs.
- `start` and `abort` together in IDLE: stay in IDLE.
- Reset, asserted at any time: state = IDLE, row = col = 0, all outputs 0. Release mid-frame does not resume the frame.

## Timing
- All outputs are registered. Reset value of every output is 0.
- `start` sampled at edge 0: FETCH in cycle 1, WAIT in cycles 2..1+FETCH_LAT, PRESENT from cycle 2+FETCH_LAT.
- Minimum block period is 2+FETCH_LAT cycles: 4 at default, with `blk_ready` tied high.
- Each stall cycle (`blk_ready` = 0 in PRESENT) adds one cycle. `blk_valid` never deasserts without a handshake, except on abort or reset.
- `frame_done` asserts the cycle after the last handshake. `busy` drops one cycle later.
- `ext_enable` is never high while `blk_valid` is high.

## Structure
- Shared package `intra_pkg`:
  - state enum {IDLE, FETCH, WAIT, PRESENT, DONE};
  - MBNUM_W = 13;
  - NCOL/NROW derivation helpers, reused by the extractor and predictor.
- One natural sub-module, `mb_addr_counter`:
  - holds the row/col counters with wrap;
  - produces `mbnumber` (row*NCOL+col, computed as a shift when NCOL is a power of two);
  - produces the avail flags and the last-block flag;
  - inputs: clear and advance.
- Top-level: FSM plus the FETCH_LAT wait counter, width $clog2(FETCH_LAT+1).

## Test plan
- Reset held low with `start`/`blk_ready` toggling → all outputs 0. Release, then `start` → `ext_enable` in cycle 1 with `mbnumber` = 0, and `blk_valid` in cycle 4.
- LENGTH = WIDTH = 16, FETCH_LAT = 2, `blk_ready` = 1:
  - `mbnumber` steps 0..15, block k valid in cycle 4k+4;
  - `frame_done` in cycle 65, `busy` low from cycle 66;
  - `left_avail` = 0 at mbnumber 0/4/8/12, `top_avail` = 0 at 0..3.
- Backpressure: `blk_ready` low for 5 cycles on block 2 → `blk_valid` and `mbnumber` = 2 held stable for 6 cycles, no `ext_enable`, block 3 FETCH the cycle after the handshake.
- Abort in WAIT of block 5, and separately abort coincident with the block-7 handshake → IDLE next cycle, no `frame_done`. A following `start` restarts at `mbnumber` = 0.
- `start` pulsed during PRESENT → ignored, the frame completes normally with a single `frame_done`.
- Reset asserted asynchronously mid-PRESENT → `blk_valid`, `busy`, `mbnumber` go to 0 immediately, without waiting for a clock edge. After release the block stays in IDLE until `start`.
